// File: rtl/i2s_rx_core_pkg.sv
// Shared I2S receive definitions: control-field codes, RX FSM states and word-assembly helpers.
package i2s_rx_core_pkg;

    localparam int unsigned RX_DW = 32;

    localparam logic [1:0] I2S_DAT_8_BITS  = 2'b00;
    localparam logic [1:0] I2S_DAT_16_BITS = 2'b01;
    localparam logic [1:0] I2S_DAT_24_BITS = 2'b10;
    localparam logic [1:0] I2S_DAT_32_BITS = 2'b11;

    localparam logic [1:0] I2S_FMT_PHILIPS = 2'b00;
    localparam logic [1:0] I2S_FMT_LJ      = 2'b01;

    localparam logic [1:0] I2S_CHM_STEREO = 2'b00;
    localparam logic [1:0] I2S_CHM_LEFT   = 2'b01;
    localparam logic [1:0] I2S_CHM_RIGHT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ALIGN = 2'b01,
        ST_RECV  = 2'b10,
        ST_HOLD  = 2'b11
    } rx_state_e;

    typedef struct packed {
        logic             chl;
        logic [RX_DW-1:0] data;
    } rx_word_t;

    function automatic logic [5:0] word_bits(input logic [1:0] chl);
        case (chl)
            I2S_DAT_8_BITS:  return 6'd8;
            I2S_DAT_16_BITS: return 6'd16;
            I2S_DAT_24_BITS: return 6'd24;
            default:         return 6'd32;
        endcase
    endfunction

    // Position of serial bit number cnt inside the MSB-aligned output word.
    function automatic logic [4:0] bit_idx(input logic lsb, input logic [1:0] chl,
                                           input logic [5:0] cnt);
        logic [5:0] idx;
        idx = lsb ? (6'd32 - word_bits(chl) + cnt) : (6'd31 - cnt);
        return idx[4:0];
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the external sck/ws/sd into the clk_i domain and flags rising edges of sck.
module i2s_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic sck_re_c,
    output logic ws_o,
    output logic sd_o
);

    logic [SYNC_STAGES-1:0] sck_q, sck_d;
    logic [SYNC_STAGES-1:0] ws_q, ws_d;
    logic [SYNC_STAGES-1:0] sd_q, sd_d;
    logic                   sck_prev_q, sck_prev_d;

    always_comb begin
        sck_d      = {sck_q[SYNC_STAGES-2:0], sck_i};
        ws_d       = {ws_q[SYNC_STAGES-2:0], ws_i};
        sd_d       = {sd_q[SYNC_STAGES-2:0], sd_i};
        sck_prev_d = sck_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sck_q      <= '0;
            ws_q       <= '0;
            sd_q       <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign sck_re_c = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign ws_o     = ws_q[SYNC_STAGES-1];
    assign sd_o     = sd_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_core.sv
// Slave-mode I2S receiver: aligns to slot starts, assembles 8..32-bit words and
// presents them on a valid/ready stream with a sticky overflow flag.
module i2s_rx_core
    import i2s_rx_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  lsb_i,
    input  logic [1:0]            fmt_i,
    input  logic [1:0]            chm_i,
    input  logic [1:0]            chl_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_chl_o,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i
);

    logic sck_re_c, ws_s, sd_s;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .sck_i    (i2s_sck_i),
        .ws_i     (i2s_ws_i),
        .sd_i     (i2s_sd_i),
        .sck_re_c (sck_re_c),
        .ws_o     (ws_s),
        .sd_o     (sd_s)
    );

    rx_state_e        state_q, state_d;
    logic             ws_prev_q, ws_prev_d;
    logic             ws_vld_q, ws_vld_d;
    logic             pend_q, pend_d;
    logic             pend_ch_q, pend_ch_d;
    logic             slot_ch_q, slot_ch_d;
    logic [1:0]       cfg_chl_q, cfg_chl_d;
    logic             cfg_lsb_q, cfg_lsb_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [RX_DW-1:0] shift_q, shift_d;
    rx_word_t         out_q, out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;

    logic is_lj_c, ws_chg_c, slot_start_c, start_ch_c, last_bit_c, keep_c;
    logic word_done_c, ovf_set_c;

    // Philips slots start one sck after the ws change; left-justified on the change itself.
    assign is_lj_c      = (fmt_i == I2S_FMT_LJ);
    assign ws_chg_c     = ws_vld_q && (ws_s != ws_prev_q);
    assign slot_start_c = sck_re_c && (is_lj_c ? ws_chg_c : pend_q);
    assign start_ch_c   = is_lj_c ? ws_s : pend_ch_q;
    assign last_bit_c   = (bit_cnt_q + 6'd1) == word_bits(cfg_chl_q);
    assign keep_c       = (chm_i == I2S_CHM_LEFT)  ? !slot_ch_q :
                          (chm_i == I2S_CHM_RIGHT) ?  slot_ch_q : 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_ALIGN;
                ST_ALIGN: if (slot_start_c) state_d = ST_RECV;
                ST_RECV: begin
                    if (slot_start_c)                 state_d = ST_RECV;
                    else if (sck_re_c && last_bit_c)  state_d = ST_HOLD;
                end
                ST_HOLD:  if (slot_start_c) state_d = ST_RECV;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ws_prev_d   = ws_prev_q;
        ws_vld_d    = ws_vld_q;
        pend_d      = pend_q;
        pend_ch_d   = pend_ch_q;
        slot_ch_d   = slot_ch_q;
        cfg_chl_d   = cfg_chl_q;
        cfg_lsb_d   = cfg_lsb_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_d       = out_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        word_done_c = 1'b0;
        ovf_set_c   = 1'b0;

        // ws tracking runs even while disabled so re-enable aligns to a real change.
        if (sck_re_c) begin
            ws_prev_d = ws_s;
            ws_vld_d  = 1'b1;
            pend_d    = !is_lj_c && ws_chg_c;
            if (ws_chg_c) pend_ch_d = ws_s;
        end

        if (!en_i) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (slot_start_c && (state_q != ST_IDLE)) begin
            cfg_chl_d = chl_i;
            cfg_lsb_d = lsb_i;
            slot_ch_d = start_ch_c;
            shift_d   = '0;
            shift_d[bit_idx(lsb_i, chl_i, 6'd0)] = sd_s;
            bit_cnt_d = 6'd1;
        end else if (sck_re_c && (state_q == ST_RECV)) begin
            shift_d[bit_idx(cfg_lsb_q, cfg_chl_q, bit_cnt_q)] = sd_s;
            bit_cnt_d   = bit_cnt_q + 6'd1;
            word_done_c = last_bit_c;
        end

        if (valid_q && rx_ready_i) valid_d = 1'b0;
        if (word_done_c && keep_c) begin
            if (!valid_q || rx_ready_i) begin
                out_d.chl  = slot_ch_q;
                out_d.data = shift_d;
                valid_d    = 1'b1;
            end else begin
                ovf_set_c = 1'b1;
            end
        end
        if (!en_i) valid_d = 1'b0;

        if (ovf_clr_i) ovf_d = 1'b0;
        if (ovf_set_c) ovf_d = 1'b1;

        busy_d = (state_d == ST_RECV);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ws_prev_q <= 1'b0;
            ws_vld_q  <= 1'b0;
            pend_q    <= 1'b0;
            pend_ch_q <= 1'b0;
            slot_ch_q <= 1'b0;
            cfg_chl_q <= I2S_DAT_8_BITS;
            cfg_lsb_q <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ws_prev_q <= ws_prev_d;
            ws_vld_q  <= ws_vld_d;
            pend_q    <= pend_d;
            pend_ch_q <= pend_ch_d;
            slot_ch_q <= slot_ch_d;
            cfg_chl_q <= cfg_chl_d;
            cfg_lsb_q <= cfg_lsb_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign ovf_o      = ovf_q;
    assign rx_valid_o = valid_q;
    assign rx_data_o  = DATA_WIDTH'(out_q.data);
    assign rx_chl_o   = out_q.chl;

endmodule

// File: tb/tb_i2s_rx_core.sv
// Directed bench for i2s_rx_core: plays hand-built I2S bit streams and checks the received words.
module tb_i2s_rx_core;

    logic        clk_i = 1'b0;
    logic        rst_n_i, en_i, lsb_i, ovf_clr_i, rx_ready_i;
    logic [1:0]  fmt_i, chm_i, chl_i;
    logic        busy_o, ovf_o, rx_valid_o, rx_chl_o;
    logic [31:0] rx_data_o;
    logic        i2s_sck_i, i2s_ws_i, i2s_sd_i;

    int n_pass = 0;
    int n_chk  = 0;

    bit          ws_q[$];
    bit          sd_q[$];
    logic [32:0] got_q[$];

    i2s_rx_core #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (en_i),
        .lsb_i      (lsb_i),
        .fmt_i      (fmt_i),
        .chm_i      (chm_i),
        .chl_i      (chl_i),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_o  (rx_data_o),
        .rx_chl_o   (rx_chl_o),
        .i2s_sck_i  (i2s_sck_i),
        .i2s_ws_i   (i2s_ws_i),
        .i2s_sd_i   (i2s_sd_i)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 2 ns after a rising edge, so the falling edge sees what the next rising edge will.
    always @(negedge clk_i)
        if (rst_n_i && rx_valid_o && rx_ready_i) got_q.push_back({rx_chl_o, rx_data_o});

    function automatic logic [32:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 33'bx;
    endfunction

    task automatic add_part(input bit ws, input logic [31:0] val, input int nbits,
                            input bit lsb, input int from, input int to);
        for (int i = from; i < to; i++) begin
            ws_q.push_back(ws);
            sd_q.push_back(lsb ? val[i] : val[nbits-1-i]);
        end
    endtask

    task automatic add_slot(input bit ws, input logic [31:0] val, input int nbits, input bit lsb);
        add_part(ws, val, nbits, lsb, 0, nbits);
    endtask

    // One bit per 160 ns sck period; Philips moves each ws transition one bit earlier.
    task automatic play(input bit philips, input int pulse_idx);
        int n;
        n = ws_q.size();
        for (int i = 0; i < n; i++) begin
            i2s_sck_i = 1'b0;
            i2s_ws_i  = (philips && (i + 1 < n)) ? ws_q[i+1] : ws_q[i];
            i2s_sd_i  = sd_q[i];
            #80;
            i2s_sck_i = 1'b1;
            if (i == pulse_idx) begin
                #20 rx_ready_i = 1'b1;
                #10 rx_ready_i = 1'b0;
                #50;
            end else begin
                #80;
            end
        end
        ws_q.delete();
        sd_q.delete();
    endtask

    task automatic do_reset();
        i2s_sck_i = 1'b0;
        rst_n_i   = 1'b0;
        #30;
        rst_n_i   = 1'b1;
        #10;
    endtask

    task automatic setup(input logic [1:0] fmt, input logic [1:0] chl, input bit lsb,
                         input logic [1:0] chm, input bit rdy);
        fmt_i = fmt; chl_i = chl; lsb_i = lsb; chm_i = chm;
        rx_ready_i = rdy; ovf_clr_i = 1'b0; en_i = 1'b0;
        got_q.delete();
        do_reset();
        en_i = 1'b1;
        #20;
    endtask

    task automatic test_reset();
        en_i = 1'b0; fmt_i = 2'b00; chl_i = 2'b00; lsb_i = 1'b0; chm_i = 2'b00;
        rx_ready_i = 1'b0; ovf_clr_i = 1'b0; i2s_ws_i = 1'b0; i2s_sd_i = 1'b0;
        do_reset();
        n_chk++; if (rx_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rx_valid_o); else n_pass++;
        n_chk++; if (rx_data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", rx_data_o); else n_pass++;
        n_chk++; if (rx_chl_o !== 1'b0) $display("FAIL reset_chl got=%b exp=0", rx_chl_o); else n_pass++;
        n_chk++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
    endtask

    task automatic test_philips16();
        setup(2'b00, 2'b01, 1'b0, 2'b00, 1'b1);
        add_part(1'b1, 32'h15, 8, 1'b0, 0, 5);
        add_slot(1'b0, 32'hA5C3, 16, 1'b0);
        add_slot(1'b1, 32'h1234, 16, 1'b0);
        add_part(1'b0, 32'h0, 16, 1'b0, 0, 2);
        play(1'b1, -1);
        #20;
        n_chk++; if (got_q.size() !== 2) $display("FAIL philips_count got=%0d exp=2", got_q.size()); else n_pass++;
        n_chk++; if (got_at(0) !== {1'b0, 32'hA5C30000}) $display("FAIL philips_left got=%h exp=0a5c30000", got_at(0)); else n_pass++;
        n_chk++; if (got_at(1) !== {1'b1, 32'h12340000}) $display("FAIL philips_right got=%h exp=112340000", got_at(1)); else n_pass++;
    endtask

    task automatic test_lj_lsb32();
        setup(2'b01, 2'b11, 1'b1, 2'b00, 1'b1);
        add_part(1'b1, 32'h5, 8, 1'b0, 0, 3);
        add_slot(1'b0, 32'h80000001, 32, 1'b1);
        add_slot(1'b1, 32'h00000003, 32, 1'b1);
        add_part(1'b0, 32'h0, 16, 1'b0, 0, 2);
        play(1'b0, -1);
        #20;
        n_chk++; if (got_q.size() !== 2) $display("FAIL lj_count got=%0d exp=2", got_q.size()); else n_pass++;
        n_chk++; if (got_at(0) !== {1'b0, 32'h80000001}) $display("FAIL lj_left got=%h exp=080000001", got_at(0)); else n_pass++;
        n_chk++; if (got_at(1) !== {1'b1, 32'h00000003}) $display("FAIL lj_right got=%h exp=100000003", got_at(1)); else n_pass++;
    endtask

    task automatic test_short_word();
        setup(2'b00, 2'b00, 1'b0, 2'b00, 1'b1);
        add_part(1'b1, 32'h5, 8, 1'b0, 0, 3);
        add_slot(1'b0, 32'hDEADBEEF, 32, 1'b0);
        add_slot(1'b1, 32'h12345678, 32, 1'b0);
        add_part(1'b0, 32'h0, 16, 1'b0, 0, 2);
        play(1'b1, -1);
        #20;
        n_chk++; if (got_q.size() !== 2) $display("FAIL short_count got=%0d exp=2", got_q.size()); else n_pass++;
        n_chk++; if (got_at(0) !== {1'b0, 32'hDE000000}) $display("FAIL short_left got=%h exp=0de000000", got_at(0)); else n_pass++;
        n_chk++; if (got_at(1) !== {1'b1, 32'h12000000}) $display("FAIL short_right got=%h exp=112000000", got_at(1)); else n_pass++;
    endtask

    task automatic test_left_only();
        logic [31:0] lv;
        setup(2'b00, 2'b01, 1'b0, 2'b01, 1'b1);
        add_part(1'b1, 32'h5, 8, 1'b0, 0, 3);
        for (int f = 0; f < 4; f++) begin
            add_slot(1'b0, 32'h1111 * (f + 1), 16, 1'b0);
            add_slot(1'b1, 32'hAAAA, 16, 1'b0);
        end
        add_part(1'b0, 32'h0, 16, 1'b0, 0, 2);
        play(1'b1, -1);
        #20;
        n_chk++; if (got_q.size() !== 4) $display("FAIL left_only_count got=%0d exp=4", got_q.size()); else n_pass++;
        for (int f = 0; f < 4; f++) begin
            lv = (32'h1111 * (f + 1)) << 16;
            n_chk++; if (got_at(f) !== {1'b0, lv}) $display("FAIL left_only_word%0d got=%h exp=0%h", f, got_at(f), lv); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        setup(2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
        add_part(1'b1, 32'h5, 8, 1'b0, 0, 3);
        add_slot(1'b0, 32'h11, 8, 1'b0);
        add_slot(1'b1, 32'h22, 8, 1'b0);
        add_slot(1'b0, 32'h33, 8, 1'b0);
        play(1'b0, -1);
        #20;
        n_chk++; if (rx_valid_o !== 1'b1) $display("FAIL ovf_held_valid got=%b exp=1", rx_valid_o); else n_pass++;
        n_chk++; if ({rx_chl_o, rx_data_o} !== {1'b0, 32'h11000000}) $display("FAIL ovf_held_word got=%h exp=011000000", {rx_chl_o, rx_data_o}); else n_pass++;
        n_chk++; if (ovf_o !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf_o); else n_pass++;
        ovf_clr_i = 1'b1;
        #10 ovf_clr_i = 1'b0;
        #10;
        n_chk++; if (ovf_o !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf_o); else n_pass++;
        // ready is high only in the cycle the next word completes
        add_slot(1'b1, 32'h44, 8, 1'b0);
        add_part(1'b0, 32'h0, 8, 1'b0, 0, 2);
        play(1'b0, 7);
        #20;
        n_chk++; if (got_at(0) !== {1'b0, 32'h11000000}) $display("FAIL same_cycle_xfer got=%h exp=011000000", got_at(0)); else n_pass++;
        n_chk++; if ({rx_valid_o, rx_chl_o, rx_data_o} !== {2'b11, 32'h44000000}) $display("FAIL same_cycle_load got=%h exp=344000000", {rx_valid_o, rx_chl_o, rx_data_o}); else n_pass++;
        n_chk++; if (ovf_o !== 1'b0) $display("FAIL same_cycle_ovf got=%b exp=0", ovf_o); else n_pass++;
        rx_ready_i = 1'b1;
        #20 rx_ready_i = 1'b0;
        n_chk++; if (got_q.size() !== 2 || got_at(1) !== {1'b1, 32'h44000000}) $display("FAIL ovf_drain got=%0d/%h exp=2/144000000", got_q.size(), got_at(1)); else n_pass++;
    endtask

    task automatic test_enable();
        setup(2'b01, 2'b01, 1'b0, 2'b00, 1'b0);
        add_part(1'b1, 32'h5, 8, 1'b0, 0, 3);
        add_slot(1'b0, 32'hBEEF, 16, 1'b0);
        add_part(1'b1, 32'h5555, 16, 1'b0, 0, 7);
        play(1'b0, -1);
        n_chk++; if ({rx_valid_o, rx_data_o} !== {1'b1, 32'hBEEF0000}) $display("FAIL en_pre_word got=%h exp=1beef0000", {rx_valid_o, rx_data_o}); else n_pass++;
        en_i = 1'b0;
        #10;
        n_chk++; if (rx_valid_o !== 1'b0) $display("FAIL en_drop_valid got=%b exp=0", rx_valid_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL en_drop_busy got=%b exp=0", busy_o); else n_pass++;
        rx_ready_i = 1'b1;
        add_part(1'b1, 32'h5555, 16, 1'b0, 7, 16);
        add_part(1'b0, 32'h7777, 16, 1'b0, 0, 5);
        play(1'b0, -1);
        en_i = 1'b1;
        #20;
        add_part(1'b0, 32'h7777, 16, 1'b0, 5, 16);
        add_slot(1'b1, 32'h9ABC, 16, 1'b0);
        add_part(1'b0, 32'h0, 16, 1'b0, 0, 2);
        play(1'b0, -1);
        #20;
        n_chk++; if (got_q.size() !== 1) $display("FAIL en_count got=%0d exp=1", got_q.size()); else n_pass++;
        n_chk++; if (got_at(0) !== {1'b1, 32'h9ABC0000}) $display("FAIL en_word got=%h exp=19abc0000", got_at(0)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        setup(2'b01, 2'b01, 1'b0, 2'b00, 1'b1);
        add_part(1'b1, 32'h5, 8, 1'b0, 0, 3);
        add_slot(1'b0, 32'h1357, 16, 1'b0);
        add_part(1'b1, 32'h2468, 16, 1'b0, 0, 6);
        play(1'b0, -1);
        n_chk++; if (got_at(0) !== {1'b0, 32'h13570000}) $display("FAIL rst_mid_first got=%h exp=013570000", got_at(0)); else n_pass++;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL rst_mid_busy_pre got=%b exp=1", busy_o); else n_pass++;
        do_reset();
        n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy_o); else n_pass++;
        add_part(1'b1, 32'h2468, 16, 1'b0, 6, 16);
        add_slot(1'b0, 32'hCAFE, 16, 1'b0);
        add_part(1'b1, 32'h0, 16, 1'b0, 0, 2);
        play(1'b0, -1);
        #20;
        n_chk++; if (got_q.size() !== 2) $display("FAIL rst_mid_count got=%0d exp=2", got_q.size()); else n_pass++;
        n_chk++; if (got_at(1) !== {1'b0, 32'hCAFE0000}) $display("FAIL rst_mid_word got=%h exp=0cafe0000", got_at(1)); else n_pass++;
    endtask

    initial begin
        rst_n_i = 1'b0; en_i = 1'b0; lsb_i = 1'b0; fmt_i = 2'b00; chm_i = 2'b00; chl_i = 2'b00;
        ovf_clr_i = 1'b0; rx_ready_i = 1'b0;
        i2s_sck_i = 1'b0; i2s_ws_i = 1'b0; i2s_sd_i = 1'b0;
        #7;
        test_reset();
        test_philips16();
        test_lj_lsb32();
        test_short_word();
        test_left_only();
        test_overflow();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
